// File: rtl/noc_vc_link_arbiter.sv
// Purpose: shares one torus link between VC_W virtual channels (round-robin, wormhole lock, downstream credits).
// Latency: o_pop is combinational in the grant cycle; the flit appears on the link register exactly one cycle later.
// Backpressure: only downstream credits; a VC with an empty FIFO or zero credit is simply not granted (bubble if locked).
module noc_vc_link_arbiter #(
    parameter int VC_W    = 3,
    parameter int D_W     = 32,
    parameter int A_W     = 4,
    parameter int CREDITS = 31,
    localparam int CNT_W  = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VC_W-1:0]       i_valid,
    input  logic [VC_W*D_W-1:0]   i_data,
    input  logic [VC_W*A_W-1:0]   i_addr,
    input  logic [VC_W-1:0]       i_last,
    output logic [VC_W-1:0]       o_pop,
    input  logic [VC_W-1:0]       i_credit,
    output logic                  o_valid,
    output logic [D_W-1:0]        o_data,
    output logic [A_W-1:0]        o_addr,
    output logic                  o_last,
    output logic [VC_W-1:0]       o_vc,
    output logic                  o_credit_err
);
    localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   lock_q, lock_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q [VC_W];
    logic [CNT_W-1:0]   cnt_d [VC_W];
    logic               err_q, err_d;

    logic [VC_W-1:0]    elig;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   rr_cand;
    logic               pop_vld;
    logic [IDX_W-1:0]   pop_idx;

    logic               o_valid_q;
    logic [D_W-1:0]     o_data_q;
    logic [A_W-1:0]     o_addr_q;
    logic               o_last_q;
    logic [VC_W-1:0]    o_vc_q;

    // A VC may be granted only if its head is valid and the credit count before this cycle's update is non-zero.
    always_comb begin
        elig = '0;
        for (int v = 0; v < VC_W; v++) begin
            elig[v] = i_valid[v] && (cnt_q[v] != '0);
        end
    end

    // Round-robin search starting just after the last granted VC.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        rr_cand  = ptr_q;
        for (int k = 1; k <= VC_W; k++) begin
            rr_cand = IDX_W'((int'(ptr_q) + k) % VC_W);
            if (!rr_found && elig[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Next-state and grant: IDLE arbitrates, LOCKED serves only the owning VC until its last flit.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        pop_vld = 1'b0;
        pop_idx = lock_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    pop_vld = 1'b1;
                    pop_idx = rr_idx;
                    ptr_d   = rr_idx;
                    lock_d  = rr_idx;
                    if (!i_last[rr_idx]) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (elig[lock_q]) begin
                    pop_vld = 1'b1;
                    pop_idx = lock_q;
                    if (i_last[lock_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            pop_vld = 1'b0;
        end
    end

    // One-hot pop decode of the granted VC.
    always_comb begin
        o_pop = '0;
        for (int v = 0; v < VC_W; v++) begin
            o_pop[v] = pop_vld && (pop_idx == IDX_W'(v));
        end
    end

    // Credit counters: pop consumes, return refunds; a refund to a full counter saturates and flags an error.
    always_comb begin
        err_d = err_q;
        for (int v = 0; v < VC_W; v++) begin
            cnt_d[v] = cnt_q[v];
            if (o_pop[v] && !i_credit[v]) begin
                cnt_d[v] = cnt_q[v] - CNT_W'(1);
            end else if (!o_pop[v] && i_credit[v]) begin
                if (cnt_q[v] == CNT_W'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CNT_W'(1);
                end
            end
        end
    end

    // Arbiter state, pointer and credit registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
            ptr_q   <= IDX_W'(VC_W - 1);
            err_q   <= 1'b0;
            for (int v = 0; v < VC_W; v++) begin
                cnt_q[v] <= CNT_W'(CREDITS);
            end
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            for (int v = 0; v < VC_W; v++) begin
                cnt_q[v] <= cnt_d[v];
            end
        end
    end

    // Link register: loads the granted flit; payload fields hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_addr_q  <= '0;
            o_last_q  <= 1'b0;
            o_vc_q    <= '0;
        end else begin
            o_valid_q <= pop_vld;
            if (pop_vld) begin
                o_data_q <= i_data[pop_idx*D_W +: D_W];
                o_addr_q <= i_addr[pop_idx*A_W +: A_W];
                o_last_q <= i_last[pop_idx];
                o_vc_q   <= o_pop;
            end
        end
    end

    assign o_valid      = o_valid_q;
    assign o_data       = o_data_q;
    assign o_addr       = o_addr_q;
    assign o_last       = o_last_q;
    assign o_vc         = o_vc_q;
    assign o_credit_err = err_q;

endmodule

// File: tb/tb_noc_vc_link_arbiter.sv
// Bench for noc_vc_link_arbiter: directed steps with hand-written grant vectors.
// Each expected grant pushes the expected link flit into a queue; a negedge monitor compares link output.
// Credit counters and the sticky error flag are checked against hand-computed constants.
module tb_noc_vc_link_arbiter;
    logic         clk;
    logic         rst;
    logic [2:0]   i_valid;
    logic [95:0]  i_data;
    logic [11:0]  i_addr;
    logic [2:0]   i_last;
    logic [2:0]   o_pop;
    logic [2:0]   i_credit;
    logic         o_valid;
    logic [31:0]  o_data;
    logic [3:0]   o_addr;
    logic         o_last;
    logic [2:0]   o_vc;
    logic         o_credit_err;

    typedef struct packed {
        logic [2:0]  vc;
        logic [31:0] data;
        logic [3:0]  addr;
        logic        last;
    } flit_t;

    flit_t exp_q[$];
    int    seq [3];
    int    n_cmp = 0;
    int    n_bad = 0;

    noc_vc_link_arbiter #(.VC_W(3), .D_W(32), .A_W(4), .CREDITS(31)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_addr       (i_addr),
        .i_last       (i_last),
        .o_pop        (o_pop),
        .i_credit     (i_credit),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_addr       (o_addr),
        .o_last       (o_last),
        .o_vc         (o_vc),
        .o_credit_err (o_credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk_data(input int v, input int s);
        return (32'(v) << 24) | 32'(s);
    endfunction

    function automatic logic [3:0] mk_addr(input int v, input int s);
        return 4'((v * 5 + s) % 16);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle of stimulus; exp_pop is the hand-computed grant for this cycle.
    task automatic step(input logic r, input logic [2:0] vld, input logic [2:0] lst,
                        input logic [2:0] cr, input logic [2:0] exp_pop);
        flit_t f;
        @(posedge clk);
        #1;
        rst      = r;
        i_valid  = vld;
        i_last   = lst;
        i_credit = cr;
        for (int v = 0; v < 3; v++) begin
            i_data[v*32 +: 32] = mk_data(v, seq[v]);
            i_addr[v*4 +: 4]   = mk_addr(v, seq[v]);
        end
        #2;
        chk("o_pop", 64'(o_pop), 64'(exp_pop));
        for (int v = 0; v < 3; v++) begin
            if (exp_pop[v]) begin
                f.vc   = 3'b001 << v;
                f.data = mk_data(v, seq[v]);
                f.addr = mk_addr(v, seq[v]);
                f.last = lst[v];
                exp_q.push_back(f);
                seq[v]++;
            end
        end
    endtask

    task automatic chk_cnt(input string nm, input int c0, input int c1, input int c2);
        chk({nm, "_cnt0"}, 64'(dut.cnt_q[0]), 64'(c0));
        chk({nm, "_cnt1"}, 64'(dut.cnt_q[1]), 64'(c1));
        chk({nm, "_cnt2"}, 64'(dut.cnt_q[2]), 64'(c2));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_valid"}, 64'(o_valid), 64'(0));
        chk({nm, "_data"},  64'(o_data),  64'(0));
        chk({nm, "_addr"},  64'(o_addr),  64'(0));
        chk({nm, "_last"},  64'(o_last),  64'(0));
        chk({nm, "_vc"},    64'(o_vc),    64'(0));
        chk({nm, "_err"},   64'(o_credit_err), 64'(0));
        chk_cnt(nm, 31, 31, 31);
    endtask

    // Monitor: every link flit must match the oldest expected flit.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL link_unexpected: got vc=%b data=%h with no flit expected at %0t", o_vc, o_data, $time);
            end else begin
                flit_t e;
                e = exp_q.pop_front();
                if (o_vc !== e.vc || o_data !== e.data || o_addr !== e.addr || o_last !== e.last) begin
                    n_bad++;
                    $display("FAIL link_flit: got vc=%b data=%h addr=%h last=%b expected vc=%b data=%h addr=%h last=%b at %0t",
                             o_vc, o_data, o_addr, o_last, e.vc, e.data, e.addr, e.last, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; i_valid = '0; i_data = '0; i_addr = '0; i_last = '0; i_credit = '0;
        for (int v = 0; v < 3; v++) seq[v] = 0;

        // Reset: no pops while rst is high, even with all VCs valid.
        step(1, 3'b111, 3'b111, 3'b000, 3'b000);
        step(1, 3'b111, 3'b111, 3'b000, 3'b000);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_reset_outputs("reset");

        // Round-robin on single-flit packets: VC0,1,2,0,1,2.
        step(0, 3'b111, 3'b111, 3'b000, 3'b001);
        step(0, 3'b111, 3'b111, 3'b000, 3'b010);
        step(0, 3'b111, 3'b111, 3'b000, 3'b100);
        step(0, 3'b111, 3'b111, 3'b000, 3'b001);
        step(0, 3'b111, 3'b111, 3'b000, 3'b010);
        step(0, 3'b111, 3'b111, 3'b000, 3'b100);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_cnt("rr", 29, 29, 29);

        // Move pointer to VC0 so VC1 wins next, then a 4-flit VC1 wormhole packet.
        step(0, 3'b001, 3'b001, 3'b000, 3'b001);
        step(0, 3'b111, 3'b101, 3'b000, 3'b010);
        step(0, 3'b111, 3'b101, 3'b000, 3'b010);
        step(0, 3'b111, 3'b101, 3'b000, 3'b010);
        step(0, 3'b111, 3'b111, 3'b000, 3'b010);
        step(0, 3'b111, 3'b111, 3'b000, 3'b100);
        step(0, 3'b111, 3'b111, 3'b000, 3'b001);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_cnt("worm", 27, 25, 28);

        // Credit exhaustion on VC0: 31 flits, then stall; one credit buys one flit.
        step(1, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 31; i++) step(0, 3'b001, 3'b001, 3'b000, 3'b001);
        step(0, 3'b001, 3'b001, 3'b000, 3'b000);
        step(0, 3'b001, 3'b001, 3'b000, 3'b000);
        chk_cnt("drain", 0, 31, 31);
        step(0, 3'b001, 3'b001, 3'b001, 3'b000);
        step(0, 3'b001, 3'b001, 3'b000, 3'b001);
        step(0, 3'b001, 3'b001, 3'b000, 3'b000);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_cnt("refill", 0, 31, 31);

        // Locked on VC2 with zero credit: bubble, VC0 held off until VC2 finishes.
        step(1, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 31; i++) step(0, 3'b100, 3'b000, 3'b000, 3'b100);
        step(0, 3'b101, 3'b000, 3'b000, 3'b000);
        step(0, 3'b101, 3'b000, 3'b000, 3'b000);
        step(0, 3'b101, 3'b000, 3'b000, 3'b000);
        chk_cnt("bubble", 31, 31, 0);
        step(0, 3'b101, 3'b000, 3'b100, 3'b000);
        step(0, 3'b101, 3'b100, 3'b000, 3'b100);
        step(0, 3'b101, 3'b101, 3'b000, 3'b001);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_cnt("resume", 30, 31, 0);

        // Same-cycle pop and credit on VC1 at count 5.
        step(1, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 26; i++) step(0, 3'b010, 3'b010, 3'b000, 3'b010);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_cnt("pre5", 31, 5, 31);
        step(0, 3'b010, 3'b010, 3'b010, 3'b010);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_cnt("same", 31, 5, 31);
        chk("err_clear", 64'(o_credit_err), 64'(0));

        // Credit overflow on VC2: saturate and latch the error.
        step(0, 3'b000, 3'b000, 3'b100, 3'b000);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_cnt("ovf", 31, 5, 31);
        chk("err_set", 64'(o_credit_err), 64'(1));
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk("err_sticky", 64'(o_credit_err), 64'(1));

        // Reset mid-packet on VC2, then VC0 wins first.
        step(0, 3'b100, 3'b000, 3'b000, 3'b100);
        step(0, 3'b100, 3'b000, 3'b000, 3'b100);
        step(1, 3'b111, 3'b111, 3'b000, 3'b000);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk_reset_outputs("midrst");
        step(0, 3'b111, 3'b111, 3'b000, 3'b001);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        chk("link_idle", 64'(o_valid), 64'(0));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/noc_vc_link_arbiter.md
Name: noc_vc_link_arbiter

Overview:
- Output-port scheduler for one torus router link.
- Shares a single physical link between VC_W virtual-channel FIFOs.
- Uses round-robin arbitration with wormhole locking: a packet keeps the link from its first flit to its last.
- Tracks per-VC downstream credits, so a flit is sent only when the downstream VC FIFO has room.
- Sits between the per-VC input FIFOs and the link register toward the neighbour router.

Parameters:
- VC_W, DEFAULT_VC_W (3): number of virtual channels, one bit per VC.
- D_W, DEFAULT_D_W (32): flit payload width.
- A_W, DEFAULT_A_W (4): destination address width.
- CREDITS, DEFAULT_VC_FIFO_DEPTH-1 (31): initial and maximum credits per VC, i.e. usable downstream FIFO entries.
- CNT_W, $clog2(CREDITS+1) (5): credit counter width. Derived; must not be overridden.

Ports:
- clk  in  1  clock. All state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  VC_W  per-VC FIFO head flit valid.
- i_data  in  VC_W*D_W  per-VC head payload; VC v occupies bits [v*D_W +: D_W].
- i_addr  in  VC_W*A_W  per-VC head destination; packed the same way.
- i_last  in  VC_W  per-VC head flit is the last flit of its packet.
- o_pop  out  VC_W  combinational, one-hot or zero; pops the granted VC FIFO this cycle.
- i_credit  in  VC_W  one credit returned per set bit per cycle.
- o_valid  out  1  registered link flit valid.
- o_data  out  D_W  registered link payload.
- o_addr  out  A_W  registered link destination.
- o_last  out  1  registered last-flit flag.
- o_vc  out  VC_W  registered one-hot VC tag of the flit on the link.
- o_credit_err  out  1  sticky flag: a credit returned to a counter already at CREDITS.

Behaviour:
- Reset (rst=1 at a clock edge, including mid-packet):
  - o_valid=0, o_data=0, o_addr=0, o_last=0, o_vc=0, o_credit_err=0.
  - All credit counters = CREDITS.
  - State = IDLE.
  - RR pointer = VC_W-1, so VC0 has highest priority first.
  - o_pop = 0 while rst=1.
  - Any partially sent packet is abandoned.
- Eligibility: elig[v] = i_valid[v] && (cnt[v] != 0).
- IDLE state:
  - Grant the first eligible VC searching ptr+1, ptr+2, … modulo VC_W.
  - On grant g: o_pop[g]=1 in the same cycle; ptr <= g.
  - If i_last[g]=0, go to LOCKED(g); otherwise stay in IDLE.
  - No eligible VC: o_pop=0, stay in IDLE.
- LOCKED(g) state:
  - Only VC g is considered; other VCs never get a grant, even if eligible.
  - If elig[g]: o_pop[g]=1; if i_last[g]=1, return to IDLE.
  - If not elig[g] (empty FIFO or zero credit): o_pop=0, hold LOCKED. This is a bubble.
- Output register and latency:
  - Link outputs are loaded the clock edge after the grant: exactly 1-cycle latency.
  - o_valid = 1 for exactly the cycles following a grant.
  - o_data, o_addr, o_last and o_vc hold their last values when o_valid=0.
  - There is no downstream back-pressure other than credits; one flit per cycle at most.
- Credits:
  - cnt[v] next = cnt[v] - o_pop[v] + i_credit[v].
  - Simultaneous pop and credit return on the same VC: count unchanged.
  - A grant may use a credit only if cnt != 0 before the update. A same-cycle returned credit cannot enable a grant from 0.
  - Credit return at cnt=CREDITS with no pop: cnt saturates at CREDITS and o_credit_err latches 1 until rst.
- Invariants:
  - o_pop is at most one-hot.
  - o_pop is never asserted to a VC with i_valid=0 or cnt=0.

Test Plan:
- Reset, then hold i_valid=3'b111 with all i_last=1 for 6 cycles.
  - Grant order VC0,1,2,0,1,2.
  - o_vc = 001,010,100,… one cycle after each pop.
  - Counters end at 29 each.
- VC1 sends a 4-flit packet (i_last on flit 4) while VC0 and VC2 are continuously valid.
  - 4 consecutive VC1 flits on the link with no interleaving.
  - Then VC2 is granted, then VC0.
- Single-VC stream on VC0 with i_credit=0.
  - Exactly 31 flits sent, then o_pop[0] stays 0.
  - Pulse i_credit[0] once: exactly one more flit sent, 2 cycles after the pulse.
- Locked on VC2 with cnt[2]=0 and VC0 valid.
  - Link idle (bubble); VC0 is not granted.
  - Return a credit to VC2: VC2 resumes and finishes its packet, then VC0 is granted.
- Same-cycle pop and i_credit on VC1 with cnt=5: cnt stays 5.
- i_credit[2]=1 at cnt=31: cnt stays 31 and o_credit_err=1.
- Assert rst mid-packet, then deassert.
  - Outputs zero, counters 31, state IDLE.
  - Next grant goes to VC0.
